// File: rtl/pipe_pkg.sv
// Shared pipeline package.
// Holds the PC-generator state encoding, the default reset PC and exception
// vector, the NOP word the IF/ID register loads on a flush, and a small helper
// that word-aligns fetch targets.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } pc_state_e;

    localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF  = 32'h0000_0008;
    localparam int          BOOT_CYCLES_DEF = 4;

    // sll $0,$0,0 -- the canonical no-op loaded by an IF/ID flush.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Fetch addresses are word aligned; low two bits of a target are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pipe_pc_gen_if.sv
// Bus between the PC generator and the rest of the front end.
//   master : the PC generator (drives pc, ifid_en, ifid_flush, fetch_valid,
//            state_o; receives nextPc and the hazard/redirect/halt requests)
//   slave  : the surrounding pipeline (IF, ID/EX, hazard unit)
// All signals are single-cycle levels sampled on the rising clock edge; there
// is no valid/ready handshake -- a request is acted on in the cycle it is high.
interface pipe_pc_gen_if;
    logic [31:0] nextPc;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        exc;
    logic        halt;
    logic        irq;
    logic [31:0] pc;
    logic        ifid_en;
    logic        ifid_flush;
    logic        fetch_valid;
    logic [1:0]  state_o;

    modport master (
        input  nextPc, stall, br_taken, br_target, jmp, jmp_target,
               exc, halt, irq,
        output pc, ifid_en, ifid_flush, fetch_valid, state_o
    );

    modport slave (
        output nextPc, stall, br_taken, br_target, jmp, jmp_target,
               exc, halt, irq,
        input  pc, ifid_en, ifid_flush, fetch_valid, state_o
    );
endinterface

// File: rtl/pc_redirect_mux.sv
// Combinational priority select of redirect sources: exc > branch > jump.
// Ports:
//   exc_i, exc_vector_i     exception request and its vector
//   br_taken_i, br_target_i resolved-taken branch and its target
//   jmp_i, jmp_target_i     jump / jr request and its target
//   redirect_o              any source is active
//   target_o                selected target, word aligned
module pc_redirect_mux
    import pipe_pkg::*;
(
    input  logic        exc_i,
    input  logic [31:0] exc_vector_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_target_i,
    output logic        redirect_o,
    output logic [31:0] target_o
);

    always_comb begin
        redirect_o = exc_i | br_taken_i | jmp_i;
        target_o   = 32'h0000_0000;
        if (exc_i) begin
            target_o = word_align(exc_vector_i);
        end else if (br_taken_i) begin
            target_o = word_align(br_target_i);
        end else if (jmp_i) begin
            target_o = word_align(jmp_target_i);
        end
    end

endmodule

// File: rtl/pipe_pc_gen.sv
// Fetch PC generator.
// Owns the PC register and the front-end sequencing FSM (BOOT/RUN/STALL/HALT):
// boot hold-off after reset, load-use stalls, one-bubble redirects and halt
// with irq/exception wake-up. Tells the IF/ID register when to load or flush.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   bus        pipe_pc_gen_if.master (nextPc in, pc/ifid_en/ifid_flush/
//              fetch_valid/state_o out, stall/redirect/halt/irq requests in)
module pipe_pc_gen
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
    parameter int          BOOT_CYCLES = BOOT_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          rst,
    pipe_pc_gen_if.master bus
);

    localparam logic [3:0] BOOT_LOAD = 4'(BOOT_CYCLES - 1);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  boot_cnt_q, boot_cnt_d;

    logic        redirect;
    logic [31:0] redirect_target;
    logic        flush;
    logic        fetch_valid;

    pc_redirect_mux u_redirect_mux (
        .exc_i        (bus.exc),
        .exc_vector_i (EXC_VECTOR),
        .br_taken_i   (bus.br_taken),
        .br_target_i  (bus.br_target),
        .jmp_i        (bus.jmp),
        .jmp_target_i (bus.jmp_target),
        .redirect_o   (redirect),
        .target_o     (redirect_target)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        boot_cnt_d  = boot_cnt_q;
        flush       = 1'b0;
        fetch_valid = 1'b0;

        case (state_q)
            ST_BOOT: begin
                // Fetch idles while the ROM settles; redirects are ignored.
                flush = 1'b1;
                if (boot_cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q - 4'd1;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    // Squash the wrong-path instruction fetched this cycle.
                    pc_d  = redirect_target;
                    flush = 1'b1;
                end else if (bus.halt) begin
                    flush   = 1'b1;
                    state_d = ST_HALT;
                end else if (bus.stall) begin
                    state_d = ST_STALL;
                end else begin
                    pc_d        = bus.nextPc;
                    fetch_valid = 1'b1;
                end
            end
            ST_STALL: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    flush   = 1'b1;
                    state_d = ST_RUN;
                end else if (!bus.stall) begin
                    // Held instruction is passed on in the first RUN cycle.
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                flush = 1'b1;
                if (bus.exc) begin
                    pc_d    = word_align(EXC_VECTOR);
                    state_d = ST_RUN;
                end else if (bus.irq) begin
                    pc_d    = bus.nextPc;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Flush implies a load so the NOP actually reaches IF/ID; while reset is
    // held, IF/ID is neither loaded nor fed a valid instruction.
    always_comb begin
        if (rst) begin
            bus.ifid_en     = 1'b0;
            bus.ifid_flush  = 1'b1;
            bus.fetch_valid = 1'b0;
        end else begin
            bus.ifid_en     = flush | ((state_q == ST_RUN) & ~bus.stall);
            bus.ifid_flush  = flush;
            bus.fetch_valid = fetch_valid;
        end
    end

    assign bus.pc      = pc_q;
    assign bus.state_o = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            boot_cnt_q <= BOOT_LOAD;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

endmodule
